// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped countdown timer on the CPU data-memory port.
//
// A 16-byte register window at BASE_ADDR holds CTRL, PRESET and COUNT, plus
// one reserved word. Enabling the timer loads COUNT from PRESET. COUNT then
// counts down to zero and raises an interrupt flag. In one-shot mode the
// timer disables itself after the interrupt. In auto-reload mode it restarts
// and the flag is a one-cycle pulse.
//
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-low reset (0 = reset)
//   addr    - byte address from the memory stage
//   byteen  - byte write enables; any nonzero value is a write
//   wdata   - byte-lane-aligned write data
//   hit     - address falls inside this timer's window (combinational)
//   rdata   - read data for the selected register, 0 when not hit (combinational)
//   irq     - level interrupt request, flag gated by CTRL.IM
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_en;
  logic [1:0]  r_mode;
  logic        r_im;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;

  logic [31:0] w_count_nxt;
  logic        w_fsm_en_clr;
  logic        w_flag_set;
  logic        w_flag_clr;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic [31:0] w_ctrl_word;
  logic [31:0] w_ctrl_merged;
  logic        w_unused;

  // Byte-granular merge: each set enable replaces that byte lane of the old value.
  function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

  // The low address bits select a byte within a word and do not affect decoding.
  assign w_unused = ^addr[1:0];

  assign hit           = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr          = hit & (byteen != 4'b0000);
  assign w_wr_ctrl     = w_wr & (addr[3:2] == OFF_CTRL);
  assign w_wr_preset   = w_wr & (addr[3:2] == OFF_PRESET);
  assign w_ctrl_word   = {28'd0, r_im, r_mode, r_en};
  assign w_ctrl_merged = f_merge(w_ctrl_word, wdata, byteen);
  assign irq           = r_irq_flag & r_im;

  // Read mux: the selected register when hit, zero otherwise.
  always_comb begin
    rdata = 32'h0000_0000;
    if (hit) begin
      case (addr[3:2])
        OFF_CTRL:   rdata = w_ctrl_word;
        OFF_PRESET: rdata = r_preset;
        OFF_COUNT:  rdata = r_count;
        default:    rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  // Next-state logic together with the COUNT update and the flag and EN side effects.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_fsm_en_clr = 1'b0;
    w_flag_set   = 1'b0;
    w_flag_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_en) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        w_count_nxt = r_preset;
        if (r_en) begin
          w_state_nxt = S_CNT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CNT: begin
        if (!r_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_count != 32'd0) begin
          w_count_nxt = r_count - 32'd1;
        end else begin
          w_state_nxt = S_INT;
          w_flag_set  = 1'b1;
        end
      end
      S_INT: begin
        w_state_nxt = S_IDLE;
        // Auto-reload keeps EN set so the timer restarts from IDLE; all other
        // modes behave as one-shot.
        if (r_mode == 2'b01) begin
          w_flag_clr = 1'b1;
        end else begin
          w_fsm_en_clr = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state and COUNT registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_count <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // CTRL register. A bus write on the same edge as the FSM's one-shot EN clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en   <= 1'b0;
      r_mode <= 2'b00;
      r_im   <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_en   <= w_ctrl_merged[0];
      r_mode <= w_ctrl_merged[2:1];
      r_im   <= w_ctrl_merged[3];
    end else if (w_fsm_en_clr) begin
      r_en   <= 1'b0;
    end
  end

  // PRESET register. It is only sampled in LOAD, so writes during a count do not disturb it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_preset <= 32'd0;
    end else if (w_wr_preset) begin
      r_preset <= f_merge(r_preset, wdata, byteen);
    end
  end

  // Interrupt flag. Software acknowledges by writing CTRL or PRESET, and that has priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq_flag <= 1'b0;
    end else if (w_wr_ctrl || w_wr_preset) begin
      r_irq_flag <= 1'b0;
    end else if (w_flag_set) begin
      r_irq_flag <= 1'b1;
    end else if (w_flag_clr) begin
      r_irq_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer. Expected values come from the timer's
// timing rules written as plain arithmetic:
//   - COUNT loads PRESET two edges after enable, then drops by one per edge down to 0.
//   - irq rises N+3 edges after enable.
//   - Auto-reload repeats every N+4 edges.
module tb_mmio_timer;
  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic        hit;
  logic [31:0] rdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .addr(addr), .byteen(byteen), .wdata(wdata),
    .hit(hit), .rdata(rdata), .irq(irq)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // The write lands on the next rising edge; returns 1 ns after that edge.
  task automatic bus_write(input logic [1:0] off, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    addr   = BASE + {28'd0, off, 2'b00};
    wdata  = d;
    byteen = be;
    @(posedge clk);
    #1;
    byteen = 4'h0;
  endtask

  task automatic rd(input logic [1:0] off, output logic [31:0] d);
    addr   = BASE + {28'd0, off, 2'b00};
    byteen = 4'h0;
    #1;
    d = rdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    byteen = 4'h0;
    rst    = 1'b0;
    #2;
    rst    = 1'b1;
    tick(1);
  endtask

  function automatic int exp_count(input int n, input int k);
    if (k < 2) return 0;
    else if (n > k - 2) return n - (k - 2);
    else return 0;
  endfunction

  task automatic test_reset();
    logic [31:0] got;
    do_reset();
    for (int off = 0; off < 4; off++) begin
      rd(off[1:0], got);
      checks++;
      if (got !== 32'h0) begin errors++; $display("FAIL reset_read off=%0d: got %h expected 00000000", off, got); end
      checks++;
      if (hit !== 1'b1) begin errors++; $display("FAIL reset_hit off=%0d: got %b expected 1", off, hit); end
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_byte_merge();
    logic [31:0] got, base_v, d, exp;
    logic [3:0]  be;
    do_reset();
    bus_write(2'd1, 32'h1122_3344, 4'hF);
    bus_write(2'd1, 32'h0000_AB00, 4'b0010);
    rd(2'd1, got);
    checks++;
    if (got !== 32'h1122_AB44) begin errors++; $display("FAIL merge_directed: got %h expected 1122ab44", got); end
    for (int t = 0; t < 8; t++) begin
      base_v = $urandom;
      d      = $urandom;
      be     = 4'($urandom_range(1, 15));
      bus_write(2'd1, base_v, 4'hF);
      bus_write(2'd1, d, be);
      for (int b = 0; b < 4; b++) exp[8*b +: 8] = be[b] ? d[8*b +: 8] : base_v[8*b +: 8];
      rd(2'd1, got);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL merge_random be=%b: got %h expected %h", be, got, exp); end
    end
    bus_write(2'd2, $urandom, 4'hF);
    rd(2'd2, got);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL count_write_ignored: got %h expected 00000000", got); end
    bus_write(2'd3, 32'hFFFF_FFFF, 4'hF);
    rd(2'd3, got);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h expected 00000000", got); end
    // Upper lanes only: CTRL bits live in byte 0, so nothing changes.
    bus_write(2'd0, 32'hFFFF_FFFF, 4'hE);
    rd(2'd0, got);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL ctrl_upper_lanes: got %h expected 00000000", got); end
    bus_write(2'd0, 32'hFFFF_FFF8, 4'h1);
    rd(2'd0, got);
    checks++;
    if (got !== 32'h8) begin errors++; $display("FAIL ctrl_upper_zero: got %h expected 00000008", got); end
    bus_write(2'd0, 32'h0, 4'hF);
  endtask

  task automatic test_oneshot(input int n, input logic [31:0] ctl);
    logic [31:0] got, ectl;
    do_reset();
    bus_write(2'd1, 32'(n), 4'hF);
    bus_write(2'd0, ctl, 4'hF);
    for (int k = 1; k <= n + 6; k++) begin
      tick(1);
      rd(2'd2, got);
      checks++;
      if (got !== 32'(exp_count(n, k))) begin errors++; $display("FAIL oneshot_count n=%0d k=%0d: got %0d expected %0d", n, k, got, exp_count(n, k)); end
      checks++;
      if (irq !== (k >= n + 3)) begin errors++; $display("FAIL oneshot_irq n=%0d k=%0d: got %b expected %b", n, k, irq, (k >= n + 3)); end
      ectl = (k >= n + 4) ? (ctl & 32'hFFFF_FFFE) : ctl;
      rd(2'd0, got);
      checks++;
      if (got !== ectl) begin errors++; $display("FAIL oneshot_ctrl n=%0d k=%0d: got %h expected %h", n, k, got, ectl); end
    end
    bus_write(2'd0, 32'h8, 4'hF);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_ack n=%0d: got %b expected 0", n, irq); end
  endtask

  task automatic test_autoreload(input int n);
    logic [31:0] got;
    int p;
    logic eirq;
    p = n + 4;
    do_reset();
    bus_write(2'd1, 32'(n), 4'hF);
    bus_write(2'd0, 32'hB, 4'hF);
    for (int k = 1; k <= 3 * p + 3; k++) begin
      tick(1);
      rd(2'd2, got);
      checks++;
      if (got !== 32'(exp_count(n, (k < 2) ? k : ((k - 2) % p) + 2))) begin
        errors++; $display("FAIL auto_count n=%0d k=%0d: got %0d", n, k, got);
      end
      eirq = (k >= n + 3) && (((k - n - 3) % p) == 0);
      checks++;
      if (irq !== eirq) begin errors++; $display("FAIL auto_irq n=%0d k=%0d: got %b expected %b", n, k, irq, eirq); end
    end
    bus_write(2'd0, 32'h0, 4'hF);
  endtask

  task automatic test_freeze();
    logic [31:0] got;
    int n, m;
    n = $urandom_range(110, 160);
    m = $urandom_range(3, 50);
    do_reset();
    bus_write(2'd1, 32'(n), 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    tick(n - 98);
    rd(2'd2, got);
    checks++;
    if (got !== 32'd100) begin errors++; $display("FAIL freeze_at100: got %0d expected 100", got); end
    bus_write(2'd0, 32'h0, 4'hF);
    for (int i = 0; i < 5; i++) begin
      rd(2'd2, got);
      checks++;
      if (got !== 32'd99) begin errors++; $display("FAIL freeze_hold i=%0d: got %0d expected 99", i, got); end
      tick(1);
    end
    bus_write(2'd1, 32'(m), 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    rd(2'd2, got);
    checks++;
    if (got !== 32'd99) begin errors++; $display("FAIL reenable_e0: got %0d expected 99", got); end
    tick(1);
    rd(2'd2, got);
    checks++;
    if (got !== 32'd99) begin errors++; $display("FAIL reenable_e1: got %0d expected 99", got); end
    tick(1);
    rd(2'd2, got);
    checks++;
    if (got !== 32'(m)) begin errors++; $display("FAIL reenable_reload: got %0d expected %0d", got, m); end
    bus_write(2'd1, $urandom, 4'hF);
    rd(2'd2, got);
    checks++;
    if (got !== 32'(m - 1)) begin errors++; $display("FAIL midcount_preset0: got %0d expected %0d", got, m - 1); end
    tick(1);
    rd(2'd2, got);
    checks++;
    if (got !== 32'(m - 2)) begin errors++; $display("FAIL midcount_preset1: got %0d expected %0d", got, m - 2); end
  endtask

  task automatic test_race();
    logic [31:0] got;
    int n;
    n = $urandom_range(0, 8);
    do_reset();
    bus_write(2'd1, 32'(n), 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    tick(n + 3);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL race_irq_up n=%0d: got %b expected 1", n, irq); end
    bus_write(2'd0, 32'h9, 4'hF);
    rd(2'd0, got);
    checks++;
    if (got !== 32'h9) begin errors++; $display("FAIL race_ctrl n=%0d: got %h expected 00000009", n, got); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL race_irq_ack n=%0d: got %b expected 0", n, irq); end
    bus_write(2'd2, 32'hFFFF_FFFF, 4'hF);
    tick(1);
    rd(2'd2, got);
    checks++;
    if (got !== 32'(n)) begin errors++; $display("FAIL race_reload n=%0d: got %0d expected %0d", n, got, n); end
    bus_write(2'd0, 32'h0, 4'hF);
  endtask

  task automatic test_outside();
    logic [31:0] got, p, a;
    p = $urandom;
    do_reset();
    bus_write(2'd1, p, 4'hF);
    bus_write(2'd0, 32'h6, 4'hF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = $urandom;
      if (a[31:4] == BASE[31:4]) a = a ^ 32'h0000_0100;
      addr   = a;
      wdata  = $urandom;
      byteen = 4'hF;
      #1;
      checks++;
      if (hit !== 1'b0) begin errors++; $display("FAIL outside_hit a=%h: got %b expected 0", a, hit); end
      checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL outside_rdata a=%h: got %h expected 00000000", a, rdata); end
      @(posedge clk);
      #1;
      byteen = 4'h0;
    end
    rd(2'd1, got);
    checks++;
    if (got !== p) begin errors++; $display("FAIL outside_preset: got %h expected %h", got, p); end
    rd(2'd0, got);
    checks++;
    if (got !== 32'h6) begin errors++; $display("FAIL outside_ctrl: got %h expected 00000006", got); end
  endtask

  task automatic test_async_reset(input int n, input int ticks);
    logic [31:0] got;
    do_reset();
    bus_write(2'd1, 32'(n), 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    tick(ticks);
    rd(2'd2, got);
    checks++;
    if (got !== 32'(exp_count(n, ticks))) begin errors++; $display("FAIL areset_pre_count: got %0d expected %0d", got, exp_count(n, ticks)); end
    checks++;
    if (irq !== (ticks >= n + 3)) begin errors++; $display("FAIL areset_pre_irq: got %b expected %b", irq, (ticks >= n + 3)); end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL areset_irq: got %b expected 0", irq); end
    for (int off = 0; off < 3; off++) begin
      rd(off[1:0], got);
      checks++;
      if (got !== 32'h0) begin errors++; $display("FAIL areset_reg off=%0d: got %h expected 00000000", off, got); end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst    = 1'b0;
    addr   = 32'h0;
    byteen = 4'h0;
    wdata  = 32'h0;
    #12;
    rst = 1'b1;
    test_reset();
    test_byte_merge();
    test_oneshot(5, 32'h9);
    test_oneshot(0, 32'h9);
    test_oneshot($urandom_range(1, 15), 32'hD);
    test_oneshot($urandom_range(1, 15), 32'hF);
    test_autoreload(2);
    test_autoreload(0);
    test_autoreload($urandom_range(1, 6));
    test_freeze();
    test_race();
    test_outside();
    test_async_reset(3, 6);
    test_async_reset(40, 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
